seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
- Sequencer that feeds the 1101 Mealy sequence detector from a parallel word stream.
- Accepts frames of WORD_W-bit words over a valid/ready handshake and serializes each word MSB-first onto the detector's serial input, one bit per cycle.
- Clears the detector at the start of each frame, counts detector matches per frame, and reports frame completion or underrun.
- Sits between the packet-side word interface and one detector instance.

Parameters:
- WORD_W, 8: width of input words; bits per word shifted to the detector.
- CNT_W, 8: width of match_count; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  single clock; all logic on posedge.
- sync_reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  controller accepts the word this cycle.
- in_data  input  WORD_W  word to serialize, MSB sent first.
- in_last  input  1  accepted word is the last word of the frame.
- det_in_stream  output  1  serial bit to the detector's in_stream.
- det_sync_reset  output  1  drives the detector's sync_reset (active-high).
- det_out  input  1  detector's registered match output.
- match_count  output  CNT_W  matches in the current or last frame.
- frame_done  output  1  one-cycle pulse at frame end.
- frame_err  output  1  frame ended by underrun; held until the next frame starts.
- busy  output  1  state != IDLE.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-low (sync_reset_n).
- Reset (sync_reset_n=0 at posedge) forces:
  - state=IDLE, match_count=0, frame_done=0, frame_err=0, bit_v_d=0, shift reg=0.
  - det_sync_reset = ~sync_reset_n | (state==CLEAR), so the detector is held reset while the controller is in reset.
- A reset mid-frame aborts the frame with no frame_done.
- FSM states are IDLE, CLEAR, SHIFT, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: load shreg=in_data, last_f=in_last, bit_cnt=WORD_W-1; go to CLEAR.
- CLEAR (1 cycle):
  - det_sync_reset=1, det_in_stream=0, match_count<=0, frame_err<=0; go to SHIFT.
- SHIFT:
  - det_in_stream=shreg[WORD_W-1]; each cycle shift left by 1 and decrement bit_cnt.
  - When bit_cnt==0 and last_f==0:
    - in_ready=1.
    - If in_valid: reload shreg/last_f/bit_cnt and stay in SHIFT, with no bubble between words.
    - Else (underrun): frame_err<=1, go to DRAIN.
  - When bit_cnt==0 and last_f==1: in_ready=0, go to DRAIN.
  - in_ready=0 in all other SHIFT cycles.
- The detector has no enable, so gaps inside a frame are not permitted; an underrun terminates the frame.
- DRAIN (1 cycle): det_in_stream=0; samples det_out for the final bit; go to DONE.
- DONE (1 cycle): frame_done=1; go to IDLE.
- match_count and frame_err hold until the next CLEAR.
- Match qualification:
  - bit_v_d <= (state==SHIFT).
  - det_out lags its bit by one cycle, so count only when bit_v_d && det_out.
  - det_out during or after CLEAR is stale and must not be counted (bit_v_d=0 guarantees this).
- match_count increments by 1 and saturates at all-ones; it never wraps.
- Latency: word accepted in IDLE at cycle t → CLEAR t+1, bits t+2..t+WORD_W+1, DRAIN t+WORD_W+2, frame_done at t+WORD_W+3 with final match_count valid.
- Multi-word frame: done follows the last word's final bit by 2 cycles.
- Detector state carries across word boundaries within a frame; patterns spanning words are counted.
- in_valid while busy and not in a reload slot: ignored; the word is not consumed (in_ready=0).

Test Plan:
- Reset with sync_reset_n=0 for 2 cycles mid-SHIFT → next cycle state IDLE, in_ready=1, match_count=0, det_sync_reset=1 during reset, no frame_done.
- Single word 0xDD with in_last=1 accepted at t → bits 1,1,0,1,1,1,0,1 on det_in_stream at t+2..t+9; frame_done at t+11; match_count=2; frame_err=0.
- Frame 0x03 then 0x40 (in_last on the second) presented back-to-back → in_ready=1 on the last-bit cycle; no bubble on det_in_stream; match_count=1 (cross-word match); frame_done once.
- Word 0xB6 with in_last=0 and no second word → frame_err=1; frame_done 2 cycles after the 8th bit; match_count=1.
- CNT_W=2, four back-to-back 0xDD words (last flagged) → 8 raw matches; match_count saturates at 3.
- Two frames: 0xDD then 0x00 → second CLEAR clears the count; second frame match_count=0; stale det_out is not counted.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// Word-to-serial sequencer for a 1101 Mealy detector: clears the detector per frame,
// shifts words MSB-first with no gaps, and counts qualified matches per frame.
module seq_detect_ctrl #(
   parameter int WORD_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              sync_reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_last,
   output logic              det_in_stream,
   output logic              det_sync_reset,
   input  logic              det_out,
   output logic [CNT_W-1:0]  match_count,
   output logic              frame_done,
   output logic              frame_err,
   output logic              busy
);

   localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_e;

   state_e              state_q, state_d;
   logic [WORD_W-1:0]   shreg_q, shreg_d;
   logic                last_q, last_d;
   logic [BC_W-1:0]     bitcnt_q, bitcnt_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
   logic                bitv_q;
   logic                load;

   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         last_q   <= 1'b0;
         bitcnt_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         bitv_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         last_q   <= last_d;
         bitcnt_q <= bitcnt_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         bitv_q   <= (state_q == SHIFT);
      end
   end

   always_comb begin
      state_d       = state_q;
      shreg_d       = shreg_q;
      last_d        = last_q;
      bitcnt_d      = bitcnt_q;
      cnt_d         = cnt_q;
      err_d         = err_q;
      in_ready      = 1'b0;
      det_in_stream = 1'b0;
      load          = 1'b0;

      // det_out is registered, so a match belongs to the bit shifted one cycle earlier
      if (bitv_q && det_out && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load    = 1'b1;
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = SHIFT;
         end
         SHIFT: begin
            det_in_stream = shreg_q[WORD_W-1];
            shreg_d       = shreg_q << 1;
            bitcnt_d      = bitcnt_q - 1'b1;
            if (bitcnt_q == '0) begin
               if (!last_q) begin
                  in_ready = 1'b1;
                  if (in_valid) begin
                     load = 1'b1;
                  end else begin
                     err_d   = 1'b1;
                     state_d = DRAIN;
                  end
               end else begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (load) begin
         shreg_d  = in_data;
         last_d   = in_last;
         bitcnt_d = BC_W'(WORD_W - 1);
      end
   end

   assign det_sync_reset = ~sync_reset_n | (state_q == CLEAR);
   assign match_count    = cnt_q;
   assign frame_err      = err_q;
   assign frame_done     = (state_q == DONE);
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl with a behavioural 1101 detector in the loop;
// a second instance with a 2-bit counter exercises saturation on the same stimulus.
module tb_seq_detect_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         sync_reset_n, in_valid, in_last;
   logic [W-1:0] in_data;
   logic         in_ready, det_in_stream, det_sync_reset, frame_done, frame_err, busy;
   logic         det_out = 1'b0;
   logic [7:0]   match_count;
   logic         in_ready2, dis2, dsr2, fd2, fe2, busy2;
   logic [1:0]   match_count2;
   logic [2:0]   hist = 3'b0;

   always #5 clk = ~clk;

   seq_detect_ctrl #(.WORD_W(W), .CNT_W(8)) dut (
      .clk(clk), .sync_reset_n(sync_reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .det_in_stream(det_in_stream),
      .det_sync_reset(det_sync_reset), .det_out(det_out), .match_count(match_count),
      .frame_done(frame_done), .frame_err(frame_err), .busy(busy));

   seq_detect_ctrl #(.WORD_W(W), .CNT_W(2)) dut_sat (
      .clk(clk), .sync_reset_n(sync_reset_n), .in_valid(in_valid), .in_ready(in_ready2),
      .in_data(in_data), .in_last(in_last), .det_in_stream(dis2),
      .det_sync_reset(dsr2), .det_out(det_out), .match_count(match_count2),
      .frame_done(fd2), .frame_err(fe2), .busy(busy2));

   // Mealy 1101 detector with registered output, overlapping matches
   always @(posedge clk) begin
      if (det_sync_reset) begin
         hist    <= 3'b0;
         det_out <= 1'b0;
      end else begin
         hist    <= {hist[1:0], det_in_stream};
         det_out <= ({hist, det_in_stream} == 4'b1101);
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int cyc; int cnt; bit err;} exp_t;
   typedef struct {int cyc; bit b;} bit_t;
   exp_t fq[$];
   bit_t bq[$];
   int checks = 0;
   int errors = 0;
   logic [7:0] wbuf[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int ref_count(input bit s[$]);
      int c = 0;
      for (int i = 3; i < s.size(); i++)
         if (s[i-3] && s[i-2] && !s[i-1] && s[i]) c++;
      return c;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (sync_reset_n === 1'b1) begin
         if (bq.size() > 0 && bq[0].cyc == cyc) begin
            chk("serial_bit", det_in_stream, bq[0].b);
            void'(bq.pop_front());
         end
         if (frame_done) begin
            if (fq.size() == 0) begin
               chk("unexpected_frame_done", frame_done, 0);
            end else begin
               e = fq.pop_front();
               chk("done_cycle", cyc, e.cyc);
               chk("match_count", match_count, (e.cnt > 255) ? 255 : e.cnt);
               chk("match_count_sat", match_count2, (e.cnt > 3) ? 3 : e.cnt);
               chk("frame_err", frame_err, e.err);
            end
         end
      end
   end

   task automatic send_frame(input int n, input bit under);
      int   t0 = 0;
      int   tmo;
      bit   ok = 1;
      bit   s[$];
      exp_t e;
      bit_t bb;
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = wbuf[i];
         in_last  = (i == n - 1) && !under;
         tmo = 0;
         while (!in_ready && tmo < 100) begin
            @(negedge clk);
            tmo++;
         end
         if (!in_ready) begin
            chk("accept_timeout", in_ready, 1);
            ok = 0;
            break;
         end
         if (i == 0) t0 = cyc;
         else chk("reload_slot", cyc, t0 + 1 + W * i);
         for (int j = 0; j < W; j++) begin
            bb.cyc = t0 + 2 + W * i + j;
            bb.b   = wbuf[i][W-1-j];
            bq.push_back(bb);
            s.push_back(bb.b);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (ok) begin
         e.cyc = t0 + 3 + W * n;
         e.cnt = ref_count(s);
         e.err = under;
         fq.push_back(e);
      end
      tmo = 0;
      while (busy && tmo < 200) begin
         @(negedge clk);
         tmo++;
      end
      chk("idle_after_frame", busy, 0);
      @(negedge clk);
   endtask

   initial begin
      int tmo;
      sync_reset_n = 1'b0;
      in_valid     = 1'b0;
      in_last      = 1'b0;
      in_data      = '0;
      repeat (2) @(negedge clk);
      chk("rst_det_sync_reset", det_sync_reset, 1);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_match_count", match_count, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_frame_err", frame_err, 0);
      sync_reset_n = 1'b1;

      // abort a frame mid-shift
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
      tmo = 0;
      while (!in_ready && tmo < 100) begin @(negedge clk); tmo++; end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      repeat (3) @(negedge clk);
      chk("midframe_busy", busy, 1);
      sync_reset_n = 1'b0;
      #1 chk("midrst_det_sync_reset", det_sync_reset, 1);
      repeat (2) @(negedge clk);
      chk("midrst_det_sync_reset_held", det_sync_reset, 1);
      sync_reset_n = 1'b1;
      #1;
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_match_count", match_count, 0);
      repeat (15) @(negedge clk);

      wbuf[0] = 8'hDD;                  send_frame(1, 0);
      wbuf[0] = 8'h03; wbuf[1] = 8'h40; send_frame(2, 0);
      wbuf[0] = 8'hB6;                  send_frame(1, 1);
      for (int i = 0; i < 4; i++) wbuf[i] = 8'hDD;
      send_frame(4, 0);
      wbuf[0] = 8'hDD;                  send_frame(1, 0);
      wbuf[0] = 8'h00;                  send_frame(1, 0);

      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
         send_frame(int'($urandom_range(1, 4)), ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      chk("pending_frames", fq.size(), 0);
      chk("pending_bits", bq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
